// File: rtl/xbus_pkg.sv
// Shared definitions for the XBUS machine-cycle generator: op-codes, counter widths
// and the chip-select width helper.
package xbus_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_FETCH = 2'b01,
        OP_READ  = 2'b10,
        OP_WRITE = 2'b11
    } xbus_op_e;

    // Tick counter covers the longest cycle, 4*HALF_LEN with HALF_LEN up to 8.
    localparam int TICK_W = 6;
    localparam int WAIT_W = 8;

    function automatic int cs_width(input int num_cs);
        return (num_cs <= 2) ? 1 : $clog2(num_cs);
    endfunction

    function automatic logic is_long(input xbus_op_e op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/xbus_phase_ctr.sv
// Machine-cycle tick counter: wraps at last_tick, freezes while hold is high, and
// parks at tick 0 for one edge after reset so every run starts with a fresh cycle.
module xbus_phase_ctr
    import xbus_pkg::*;
(
    input  logic              Clock_In,
    input  logic              RESET,
    input  logic              hold,
    input  logic [TICK_W-1:0] last_tick,
    output logic [TICK_W-1:0] t,
    output logic [TICK_W-1:0] t_nxt,
    output logic              running
);

    always_comb begin
        t_nxt = t;
        if (!running) begin
            t_nxt = '0;
        end else if (hold) begin
            t_nxt = t;
        end else if (t == last_tick) begin
            t_nxt = '0;
        end else begin
            t_nxt = t + 1'b1;
        end
    end

    always_ff @(posedge Clock_In or posedge RESET) begin
        if (RESET) begin
            t       <= '0;
            running <= 1'b0;
        end else begin
            t       <= t_nxt;
            running <= 1'b1;
        end
    end

endmodule

// File: rtl/xbus_cycle_gen.sv
// XBUS machine-cycle generator: derives CPUClock and registered CE_n/OE_n/WR_n strobes.
// Define XBUS_READY_EN to stretch READ/WRITE cycles on ext_ready with a MAX_WAIT timeout.
module xbus_cycle_gen
    import xbus_pkg::*;
#(
    parameter int NUM_CS   = 2,
    parameter int HALF_LEN = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic                         Clock_In,
    input  logic                         RESET,
    input  logic [1:0]                   cmd_op,
    input  logic [cs_width(NUM_CS)-1:0]  cmd_cs,
    input  logic                         ext_ready,
    output logic [NUM_CS-1:0]            CE_n,
    output logic                         OE_n,
    output logic                         WR_n,
    output logic                         CPUClock,
    output logic                         cyc_start,
    output logic                         bus_err
);

    localparam int CS_W = cs_width(NUM_CS);
    localparam logic [TICK_W-1:0] SHORT_LAST = TICK_W'(2 * HALF_LEN - 1);
    localparam logic [TICK_W-1:0] LONG_LAST  = TICK_W'(4 * HALF_LEN - 1);

    xbus_op_e          op_q, op_nxt;
    logic [CS_W-1:0]   cs_q, cs_nxt;
    logic              legal_q, legal_nxt, cmd_legal;
    logic [TICK_W-1:0] t, t_nxt, last_tick, last_nxt;
    logic              running, start_edge, hold, timeout;

    logic [NUM_CS-1:0] ce_nxt;
    logic              oe_nxt, wr_nxt, clk_nxt, cyc_nxt, err_nxt, access;

    assign start_edge = running && (t == '0);
    assign cmd_legal  = int'(cmd_cs) < NUM_CS;
    assign last_tick  = is_long(op_q) ? LONG_LAST : SHORT_LAST;

    xbus_phase_ctr u_phase_ctr (
        .Clock_In  (Clock_In),
        .RESET     (RESET),
        .hold      (hold),
        .last_tick (last_tick),
        .t         (t),
        .t_nxt     (t_nxt),
        .running   (running)
    );

`ifdef XBUS_READY_EN
    logic [WAIT_W-1:0] wait_cnt;
    logic              at_wait_tick;

    // Only real accesses wait; an illegal cs runs as a NOP and never stalls.
    assign at_wait_tick = running && legal_q && is_long(op_q) &&
                          (t == last_tick - 1'b1) && !ext_ready;
    assign hold         = at_wait_tick && (wait_cnt <  WAIT_W'(MAX_WAIT));
    assign timeout      = at_wait_tick && (wait_cnt >= WAIT_W'(MAX_WAIT));

    always_ff @(posedge Clock_In or posedge RESET) begin
        if (RESET) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= hold ? wait_cnt + 1'b1 : '0;
        end
    end
`else
    logic unused_ready;

    assign unused_ready = ext_ready & (MAX_WAIT > 0);
    assign hold         = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Command is captured on the edge that ends tick 0 and held for the cycle.
    always_comb begin
        op_nxt    = op_q;
        cs_nxt    = cs_q;
        legal_nxt = legal_q;
        if (start_edge) begin
            op_nxt    = xbus_op_e'(cmd_op);
            cs_nxt    = cmd_cs;
            legal_nxt = cmd_legal;
        end
    end

    // Decode the strobes for the tick about to start so every output is a flop.
    always_comb begin
        last_nxt = is_long(op_nxt) ? LONG_LAST : SHORT_LAST;
        access   = (t_nxt != '0) && legal_nxt && (op_nxt != OP_NOP);
        ce_nxt   = '1;
        oe_nxt   = 1'b1;
        wr_nxt   = 1'b1;
        if (access) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (cs_nxt == CS_W'(i)) begin
                    ce_nxt[i] = 1'b0;
                end
            end
            if (op_nxt == OP_WRITE) begin
                wr_nxt = !((t_nxt >= TICK_W'(2)) && (t_nxt < last_nxt));
            end else begin
                oe_nxt = 1'b0;
            end
        end
        clk_nxt = (int'(t_nxt) % (2 * HALF_LEN)) < HALF_LEN;
        cyc_nxt = (t_nxt == '0);
        err_nxt = (start_edge && !cmd_legal) || timeout;
    end

    // Output register stage
    always_ff @(posedge Clock_In or posedge RESET) begin
        if (RESET) begin
            op_q      <= OP_NOP;
            cs_q      <= '0;
            legal_q   <= 1'b1;
            CE_n      <= '1;
            OE_n      <= 1'b1;
            WR_n      <= 1'b1;
            CPUClock  <= 1'b1;
            cyc_start <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            op_q      <= op_nxt;
            cs_q      <= cs_nxt;
            legal_q   <= legal_nxt;
            CE_n      <= ce_nxt;
            OE_n      <= oe_nxt;
            WR_n      <= wr_nxt;
            CPUClock  <= clk_nxt;
            cyc_start <= cyc_nxt;
            bus_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_xbus_cycle_gen.sv
// Bench for xbus_cycle_gen: two instances (NUM_CS=2 and NUM_CS=3) against a per-tick
// behavioural model of whole machine cycles; honours XBUS_READY_EN when defined.
module tb_xbus_cycle_gen;
    import xbus_pkg::*;

    localparam int HL = 2;
    localparam int MW = 3;
    localparam logic [7:0] RST_VEC = 8'b111_1_1_1_0_0;

    logic       Clock_In = 1'b0;
    logic       RESET    = 1'b1;
    logic [1:0] op2, op3;
    logic       cs2;
    logic [1:0] cs3;
    logic       rdy2, rdy3;
    logic [1:0] ce2;
    logic [2:0] ce3;
    logic       oe2, wr2, clk2, cyc2, err2;
    logic       oe3, wr3, clk3, cyc3, err3;
    logic [7:0] act2, act3;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    always #5 Clock_In = ~Clock_In;

    xbus_cycle_gen #(.NUM_CS(2), .HALF_LEN(HL), .MAX_WAIT(MW)) u2 (
        .Clock_In(Clock_In), .RESET(RESET), .cmd_op(op2), .cmd_cs(cs2), .ext_ready(rdy2),
        .CE_n(ce2), .OE_n(oe2), .WR_n(wr2), .CPUClock(clk2), .cyc_start(cyc2), .bus_err(err2)
    );

    xbus_cycle_gen #(.NUM_CS(3), .HALF_LEN(HL), .MAX_WAIT(MW)) u3 (
        .Clock_In(Clock_In), .RESET(RESET), .cmd_op(op3), .cmd_cs(cs3), .ext_ready(rdy3),
        .CE_n(ce3), .OE_n(oe3), .WR_n(wr3), .CPUClock(clk3), .cyc_start(cyc3), .bus_err(err3)
    );

    assign act2 = {1'b1, ce2, oe2, wr2, clk2, cyc2, err2};
    assign act3 = {ce3, oe3, wr3, clk3, cyc3, err3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    endtask

    function automatic bit ready_en();
`ifdef XBUS_READY_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int cyc_len(input logic [1:0] op);
        return (op == OP_READ || op == OP_WRITE) ? 4 * HL : 2 * HL;
    endfunction

    function automatic bit waits_apply(input logic [1:0] op, input int cs, input int n);
        return ready_en() && (op == OP_READ || op == OP_WRITE) && (cs < n);
    endfunction

    function automatic int n_waits(input logic [1:0] op, input int cs, input int n, input int nlow);
        if (!waits_apply(op, cs, n)) return 0;
        return (nlow < MW) ? nlow : MW;
    endfunction

    function automatic bit timed_out(input logic [1:0] op, input int cs, input int n, input int nlow);
        return waits_apply(op, cs, n) && (nlow > MW);
    endfunction

    // Sequence position j -> logical tick; tick len-2 repeats once per wait tick.
    function automatic int tick_of(input int j, input int len, input int w);
        if (j <= len - 2) return j;
        if (j <= len - 2 + w) return len - 2;
        return j - w;
    endfunction

    // Expected {CE_n[2:0], OE_n, WR_n, CPUClock, cyc_start, bus_err} for one tick.
    function automatic logic [7:0] exp_tick(input logic [1:0] op, input int cs, input int n,
                                            input int len, input int tt, input bit to);
        logic [2:0] ce;
        logic oe, wr, clk, cyc, err;
        ce = 3'b111;
        oe = 1'b1;
        wr = 1'b1;
        if (tt >= 1 && cs < n && op != OP_NOP) begin
            ce[cs] = 1'b0;
            if (op == OP_WRITE) wr = !(tt >= 2 && tt <= len - 2);
            else oe = 1'b0;
        end
        clk = (tt % (2 * HL)) < HL;
        cyc = (tt == 0);
        err = (tt == 1 && cs >= n) || (to && tt == len - 1);
        return {ce, oe, wr, clk, cyc, err};
    endfunction

    task automatic drive_cycle(input int k, input logic [1:0] op, input int cs, input int nlow);
        int n, len, w, occ, tt;
        bit to;
        logic r;
        n   = (k == 0) ? 2 : 3;
        len = cyc_len(op);
        w   = n_waits(op, cs, n, nlow);
        to  = timed_out(op, cs, n, nlow);
        occ = 0;
        for (int j = 0; j < len + w; j++) begin
            if (k == 0) q2.push_back(exp_tick(op, cs, n, len, tick_of(j, len, w), to));
            else        q3.push_back(exp_tick(op, cs, n, len, tick_of(j, len, w), to));
        end
        for (int j = 0; j < len + w; j++) begin
            tt = tick_of(j, len, w);
            @(negedge Clock_In);
            if (tt == len - 2) begin
                r = (occ < nlow) ? 1'b0 : 1'b1;
                occ++;
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            if (k == 0) begin
                if (j == 0) begin
                    op2 = op;
                    cs2 = 1'(cs);
                end
                rdy2 = r;
            end else begin
                if (j == 0) begin
                    op3 = op;
                    cs3 = 2'(cs);
                end
                rdy3 = r;
            end
            @(posedge Clock_In);
        end
    endtask

    always @(negedge Clock_In) begin
        if (q2.size() > 0) check("u2 tick", 32'(act2), 32'(q2.pop_front()));
        if (q3.size() > 0) check("u3 tick", 32'(act3), 32'(q3.pop_front()));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] v;
        op2 = OP_NOP; cs2 = 1'b0; rdy2 = 1'b1;
        op3 = OP_NOP; cs3 = 2'd0; rdy3 = 1'b1;
        RESET = 1'b1;

        // Hand-computed values that pin the model.
        check("pin fetch t1", 32'(exp_tick(OP_FETCH, 0, 2, 4, 1, 1'b0)), 32'(8'b110_0_1_1_0_0));
        check("pin read t7", 32'(exp_tick(OP_READ, 1, 2, 8, 7, 1'b0)), 32'(8'b101_0_1_0_0_0));
        check("pin illegal t1", 32'(exp_tick(OP_FETCH, 3, 3, 4, 1, 1'b0)), 32'(8'b111_1_1_1_0_1));
        pat = '0;
        for (int tt = 0; tt < 8; tt++) begin
            v = exp_tick(OP_READ, 1, 2, 8, tt, 1'b0);
            pat[7 - tt] = v[2];
        end
        check("pin cpuclock", 32'(pat), 32'(8'b1100_1100));
        for (int tt = 0; tt < 8; tt++) begin
            v = exp_tick(OP_WRITE, 1, 2, 8, tt, 1'b0);
            pat[7 - tt] = v[3];
        end
        check("pin wr pattern", 32'(pat), 32'(8'b1100_0001));
`ifdef XBUS_READY_EN
        check("pin wait len", 32'(cyc_len(OP_READ) + n_waits(OP_READ, 1, 2, 2)), 32'd10);
        check("pin timeout len", 32'(cyc_len(OP_READ) + n_waits(OP_READ, 1, 2, 9)), 32'd11);
        check("pin timeout flag", 32'(timed_out(OP_READ, 1, 2, 9)), 32'd1);
`else
        check("pin wait len", 32'(cyc_len(OP_READ) + n_waits(OP_READ, 1, 2, 2)), 32'd8);
        check("pin timeout flag", 32'(timed_out(OP_READ, 1, 2, 9)), 32'd0);
`endif

        repeat (3) @(posedge Clock_In);
        @(negedge Clock_In);
        check("u2 reset state", 32'(act2), 32'(RST_VEC));
        check("u3 reset state", 32'(act3), 32'(RST_VEC));
        RESET = 1'b0;
        @(posedge Clock_In);

        fork
            begin
                repeat (3) drive_cycle(0, OP_FETCH, 0, 0);
                drive_cycle(0, OP_READ, 1, 0);
                drive_cycle(0, OP_WRITE, 1, 0);
                drive_cycle(0, OP_NOP, 0, 0);
                drive_cycle(0, OP_READ, 1, 2);
                drive_cycle(0, OP_WRITE, 0, 9);
                repeat (60) drive_cycle(0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                                        int'($urandom_range(0, 5)));
            end
            begin
                drive_cycle(1, OP_FETCH, 3, 0);
                drive_cycle(1, OP_FETCH, 2, 0);
                drive_cycle(1, OP_READ, 3, 9);
                drive_cycle(1, OP_WRITE, 2, 0);
                drive_cycle(1, OP_READ, 1, 2);
                drive_cycle(1, OP_FETCH, 0, 0);
                repeat (60) drive_cycle(1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                        int'($urandom_range(0, 5)));
            end
        join

        // Reset in the middle of a WRITE, then restart.
        @(negedge Clock_In);
        op2 = OP_WRITE; cs2 = 1'b1; rdy2 = 1'b1;
        op3 = OP_WRITE; cs3 = 2'd1; rdy3 = 1'b1;
        RESET = 1'b1;
        @(negedge Clock_In);
        RESET = 1'b0;
        @(posedge Clock_In);
        repeat (4) @(posedge Clock_In);
        @(negedge Clock_In);
        check("u2 write tick4", 32'(act2), 32'(exp_tick(OP_WRITE, 1, 2, 8, 4, 1'b0)));
        check("u3 write tick4", 32'(act3), 32'(exp_tick(OP_WRITE, 1, 3, 8, 4, 1'b0)));
        #2 RESET = 1'b1;
        #1;
        check("u2 async reset", 32'(act2), 32'(RST_VEC));
        check("u3 async reset", 32'(act3), 32'(RST_VEC));
        repeat (2) @(negedge Clock_In);
        check("u2 reset held", 32'(act2), 32'(RST_VEC));
        RESET = 1'b0;
        @(posedge Clock_In);
        @(negedge Clock_In);
        check("u2 restart tick0", 32'(act2), 32'(exp_tick(OP_WRITE, 1, 2, 8, 0, 1'b0)));
        check("u3 restart tick0", 32'(act3), 32'(exp_tick(OP_WRITE, 1, 3, 8, 0, 1'b0)));
        @(negedge Clock_In);
        check("u2 restart tick1", 32'(act2), 32'(exp_tick(OP_WRITE, 1, 2, 8, 1, 1'b0)));
        check("u3 restart tick1", 32'(act3), 32'(exp_tick(OP_WRITE, 1, 3, 8, 1, 1'b0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xbus_cycle_gen.md
XBUS_CYCLE_GEN -- requirements
Module: xbus_cycle_gen

Interface
REQ-001 SHALL have parameter: NUM_CS, default 2, number of chip-enable outputs (index 0 = program space, 1 = data space).
REQ-002 SHALL have parameter: HALF_LEN, default 2, number of Clock_In ticks per CPUClock half-period (legal range 1..8).
REQ-003 SHALL have parameter: MAX_WAIT, default 15, maximum number of READY wait ticks before forced completion (legal range 1..255).
REQ-004 SHALL have port: Clock_In, input, 1, system clock.
REQ-005 SHALL have port: RESET, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port: cmd_op, input, 2, 00 NOP, 01 FETCH, 10 READ, 11 WRITE.
REQ-007 SHALL have port: cmd_cs, input, clog2(NUM_CS) (minimum 1), target chip-enable index.
REQ-008 SHALL have port: ext_ready, input, 1, external device ready (high = ready).
REQ-009 SHALL have port: CE_n, output, NUM_CS, active-low chip enables.
REQ-010 SHALL have port: OE_n, output, 1, active-low output enable.
REQ-011 SHALL have port: WR_n, output, 1, active-low write strobe.
REQ-012 SHALL have port: CPUClock, output, 1, derived CPU clock.
REQ-013 SHALL have port: cyc_start, output, 1, high during tick 0 of every machine cycle.
REQ-014 SHALL have port: bus_err, output, 1, one-tick pulse on an illegal cs value or a READY timeout.

Function
REQ-015 SHALL run continuously: one machine cycle follows another with no idle gap; tick counter t restarts at 0 for each cycle.
REQ-016 SHALL sample cmd_op/cmd_cs on the Clock_In rising edge that ends tick 0 and hold them internally for the rest of the cycle.
REQ-017 SHALL set cycle length L: 2*HALF_LEN ticks for NOP/FETCH, 4*HALF_LEN ticks for READ/WRITE (plus any wait ticks).
REQ-018 SHALL drive CPUClock high for ticks t mod 2*HALF_LEN < HALF_LEN and low otherwise; CPUClock SHALL be high at tick 0 of every cycle.
REQ-019 SHALL, for FETCH and READ, drive CE_n[cmd_cs] and OE_n low for ticks 1..L-1 and high at tick 0.
REQ-020 SHALL, for WRITE, drive CE_n[cmd_cs] low for ticks 1..L-1 and WR_n low for ticks 2..L-2; OE_n SHALL stay high.
REQ-021 SHALL, for NOP, keep all strobes high while still toggling CPUClock.
REQ-022 SHALL assert at most one CE_n bit at a time; OE_n and WR_n SHALL never be low together.
REQ-023 SHALL treat cmd_cs >= NUM_CS as NOP of the requested length and pulse bus_err at tick 1.
REQ-024 SHALL make all outputs registered and glitch-free.

Reset
REQ-025 SHALL, while RESET is high, immediately force CPUClock=1, CE_n all 1, OE_n=1, WR_n=1, cyc_start=0, bus_err=0, t=0 and the wait counter to 0, aborting any cycle in progress.
REQ-026 SHALL start a fresh cycle at tick 0 on the first Clock_In edge after RESET falls.

Configuration
REQ-027 SHALL support macro XBUS_READY_EN: when defined, a READ/WRITE cycle at tick L-2 SHALL hold t and all outputs while ext_ready=0, counting wait ticks.
REQ-028 SHALL, when XBUS_READY_EN is defined and the wait count reaches MAX_WAIT, advance regardless of ext_ready and pulse bus_err for one tick.
REQ-029 SHALL, when XBUS_READY_EN is not defined, ignore ext_ready; the port SHALL remain present and no wait logic SHALL be synthesised.

Structure
REQ-030 SHALL place op-code constants (OP_NOP/OP_FETCH/OP_READ/OP_WRITE) and the cs-width function in shared package xbus_pkg.
REQ-031 SHALL place the tick counter with hold input in one sub-module, xbus_phase_ctr; strobe decode SHALL remain in the top level.

Verification (HALF_LEN=2, NUM_CS=2, MAX_WAIT=3)
REQ-032 SHALL verify: continuous FETCH cs=0 -> CE_n=2'b10 and OE_n low for ticks 1..3, CPUClock pattern 1,1,0,0, cyc_start every 4 ticks.
REQ-033 SHALL verify: READ cs=1 -> 8-tick cycle, CE_n=2'b01 and OE_n low for ticks 1..7, CPUClock 1,1,0,0,1,1,0,0.
REQ-034 SHALL verify: WRITE cs=1 -> WR_n low for ticks 2..6, OE_n high throughout, CE_n[1] low for ticks 1..7.
REQ-035 SHALL verify: cmd_cs=3 with NUM_CS=3 and FETCH -> no CE_n low, bus_err pulse at tick 1.
REQ-036 SHALL verify, with XBUS_READY_EN: READ with ext_ready low for 2 ticks -> cycle of 10 ticks, no bus_err; ext_ready held low -> 3 wait ticks, then bus_err pulse and an 11-tick cycle.
REQ-037 SHALL verify: RESET asserted at tick 4 of a WRITE -> WR_n, CE_n and OE_n high and CPUClock=1 asynchronously; the next cycle starts at tick 0 after release.
